ext_bgcd_modinv: RTL

- Parametrised, handshaked extended binary GCD engine (HAC 14.61 style, one step per clock).
- Returns gcd(x, y) and signed Bezout coefficients with coeff_i*x + coeff_j*y = gcd.
- In inverse mode it also returns x^-1 mod y, normalised to [0, y), for RSA key generation (d = e^-1 mod phi).
- Flags non-invertible and invalid operands instead of hanging.

---
 rtl/bgcd_pkg.sv | 23 ++
 rtl/bgcd_coeff_halve.sv | 36 +++
 rtl/ext_bgcd_modinv.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bgcd_pkg.sv
// Shared types for the extended binary GCD / modular inverse engine.
// Holds FSM states, mode encodings and the worst-case completion bound.
package bgcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        TWOS,
        ITER,
        FIN,
        NORM,
        DONE
    } state_t;

    localparam logic MODE_GCD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    // Cycles from accepted start to done for a given operand width.
    function automatic int unsigned lat_bound(input int unsigned w);
        return 4 * w + 8;
    endfunction

endpackage

// File: rtl/bgcd_coeff_halve.sv
// Signed Bezout pair update for a halving step: (A,B)/2 when both are even, else ((A+y')/2, (B-x')/2).
// Combinational, zero latency; no handshake.
module bgcd_coeff_halve #(
    parameter int W  = 32,
    parameter int CW = W + 2
) (
    input  logic signed [CW-1:0] a_i,
    input  logic signed [CW-1:0] b_i,
    input  logic        [W-1:0]  xp_i,
    input  logic        [W-1:0]  yp_i,
    output logic signed [CW-1:0] a_o,
    output logic signed [CW-1:0] b_o
);

    logic signed [CW:0] xe;
    logic signed [CW:0] ye;
    logic signed [CW:0] sum_a;
    logic signed [CW:0] dif_b;

    assign xe = $signed({{(CW + 1 - W){1'b0}}, xp_i});
    assign ye = $signed({{(CW + 1 - W){1'b0}}, yp_i});

    // One extra bit so the add/sub cannot wrap before the arithmetic halve.
    always_comb begin
        sum_a = $signed({a_i[CW-1], a_i}) + ye;
        dif_b = $signed({b_i[CW-1], b_i}) - xe;
        if (!a_i[0] && !b_i[0]) begin
            a_o = a_i >>> 1;
            b_o = b_i >>> 1;
        end else begin
            a_o = sum_a[CW:1];
            b_o = dif_b[CW:1];
        end
    end

endmodule

// File: rtl/ext_bgcd_modinv.sv
// Extended binary GCD with Bezout coefficients and optional x^-1 mod y, one step per clock.
// Latency up to 4*WORD_WIDTH+8 cycles from accept; start is ignored while busy.
module ext_bgcd_modinv
    import bgcd_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int COEFF_WIDTH = WORD_WIDTH + 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          mode,
    input  logic [WORD_WIDTH-1:0]         x,
    input  logic [WORD_WIDTH-1:0]         y,
    output logic                          busy,
    output logic                          done,
    output logic [WORD_WIDTH-1:0]         gcd_result,
    output logic signed [COEFF_WIDTH-1:0] coeff_i,
    output logic signed [COEFF_WIDTH-1:0] coeff_j,
    output logic [WORD_WIDTH-1:0]         inv_result,
    output logic                          no_inverse,
    output logic                          invalid
);

    localparam int W  = WORD_WIDTH;
    localparam int CW = COEFF_WIDTH;
    localparam int KW = $clog2(W) + 1;

    state_t                state_q;
    logic                  mode_q;
    logic [W-1:0]          xs_q, ys_q, u_q, v_q;
    logic signed [CW-1:0]  a_q, b_q, c_q, d_q;
    logic [KW-1:0]         k_q;
    logic                  busy_q, done_q, noinv_q, invalid_q;
    logic [W-1:0]          gcd_q, inv_q;
    logic signed [CW-1:0]  ci_q, cj_q;

    logic signed [CW-1:0]  a_h, b_h, c_h, d_h;
    logic signed [CW-1:0]  y_ext;

    assign y_ext = $signed({{(CW - W){1'b0}}, ys_q});

    bgcd_coeff_halve #(.W(W), .CW(CW)) u_halve_ab (
        .a_i(a_q), .b_i(b_q), .xp_i(xs_q), .yp_i(ys_q), .a_o(a_h), .b_o(b_h)
    );

    bgcd_coeff_halve #(.W(W), .CW(CW)) u_halve_cd (
        .a_i(c_q), .b_i(d_q), .xp_i(xs_q), .yp_i(ys_q), .a_o(c_h), .b_o(d_h)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mode_q    <= MODE_GCD;
            xs_q      <= '0;
            ys_q      <= '0;
            u_q       <= '0;
            v_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            k_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            noinv_q   <= 1'b0;
            invalid_q <= 1'b0;
            gcd_q     <= '0;
            inv_q     <= '0;
            ci_q      <= '0;
            cj_q      <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q    <= mode;
                        xs_q      <= x;
                        ys_q      <= y;
                        k_q       <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        noinv_q   <= 1'b0;
                        invalid_q <= 1'b0;
                        gcd_q     <= '0;
                        inv_q     <= '0;
                        ci_q      <= '0;
                        cj_q      <= '0;
                        state_q   <= CHECK;
                    end
                end
                CHECK: begin
                    if (xs_q == '0 || ys_q == '0) begin
                        invalid_q <= 1'b1;
                        gcd_q     <= xs_q | ys_q;
                        ci_q      <= $signed({{(CW - 1){1'b0}}, xs_q != '0});
                        cj_q      <= $signed({{(CW - 1){1'b0}}, xs_q == '0});
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        state_q <= TWOS;
                    end
                end
                TWOS: begin
                    if (!xs_q[0] && !ys_q[0]) begin
                        xs_q <= xs_q >> 1;
                        ys_q <= ys_q >> 1;
                        k_q  <= k_q + 1'b1;
                    end else begin
                        u_q     <= xs_q;
                        v_q     <= ys_q;
                        a_q     <= CW'(1);
                        b_q     <= '0;
                        c_q     <= '0;
                        d_q     <= CW'(1);
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    if (!u_q[0]) begin
                        u_q <= u_q >> 1;
                        a_q <= a_h;
                        b_q <= b_h;
                    end else if (!v_q[0]) begin
                        v_q <= v_q >> 1;
                        c_q <= c_h;
                        d_q <= d_h;
                    end else if (u_q >= v_q) begin
                        u_q <= u_q - v_q;
                        a_q <= a_q - c_q;
                        b_q <= b_q - d_q;
                        // Only this subtraction can drive u to zero.
                        if (u_q == v_q) state_q <= FIN;
                    end else begin
                        v_q <= v_q - u_q;
                        c_q <= c_q - a_q;
                        d_q <= d_q - b_q;
                    end
                end
                FIN: begin
                    gcd_q <= v_q << k_q;
                    ci_q  <= c_q;
                    cj_q  <= d_q;
                    // A stripped common power of two also rules out an inverse.
                    if (mode_q == MODE_INV && (v_q != W'(1) || k_q != '0)) begin
                        noinv_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (mode_q == MODE_INV) begin
                        state_q <= NORM;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                NORM: begin
                    if (c_q[CW-1]) begin
                        c_q <= c_q + y_ext;
                    end else if (c_q >= y_ext) begin
                        c_q <= c_q - y_ext;
                    end else begin
                        inv_q   <= c_q[W-1:0];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign gcd_result = gcd_q;
    assign coeff_i    = ci_q;
    assign coeff_j    = cj_q;
    assign inv_result = inv_q;
    assign no_inverse = noinv_q;
    assign invalid    = invalid_q;

endmodule
